// File: rtl/count_monitor.sv
// Purpose: self-checking monitor for a loadable up-counter; predicts each count and logs mismatches.
// Latency: the compare happens on each CHECK edge; err_pulse, err_count and first_* are registered at that edge.
// Backpressure: none; the monitor observes every cycle and never stalls the counter.
module count_monitor #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16,
    parameter bit RESYNC = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             enable,
    input  logic             start,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] WIN_INIT = 16'(WINDOW);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] expected;
    logic [15:0]      win_cnt;
    logic             first_flag;
    logic [WIDTH-1:0] pred_obs;
    logic [WIDTH-1:0] pred_exp;
    logic [WIDTH-1:0] pred_run;
    logic             mismatch;
    logic             last_cmp;

    // Next value the counter should hold given this cycle's controls; load beats enable.
    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] base,
                                             input logic             ld,
                                             input logic             en,
                                             input logic [WIDTH-1:0] din);
        if (ld) begin
            return din;
        end else if (en) begin
            return base + WIDTH'(1);
        end else begin
            return base;
        end
    endfunction

    // Predictions from the observed count and from our own expectation, plus compare terms.
    always_comb begin
        pred_obs = nxt(count, load, enable, data_in);
        pred_exp = nxt(expected, load, enable, data_in);
        pred_run = RESYNC ? pred_obs : pred_exp;
        mismatch = (count != expected);
        last_cmp = (win_cnt == 16'd1);
    end

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear always wins over start, start is ignored while checking.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!clear && start) state_nxt = CHECK;
            end
            CHECK: begin
                if (clear)         state_nxt = IDLE;
                else if (last_cmp) state_nxt = DONE;
            end
            DONE: begin
                if (clear)      state_nxt = IDLE;
                else if (start) state_nxt = CHECK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run datapath: arm on start, compare/track each CHECK edge, capture the first failure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected   <= '0;
            win_cnt    <= '0;
            err_pulse  <= 1'b0;
            err_count  <= 8'd0;
            first_exp  <= '0;
            first_got  <= '0;
            first_flag <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (clear) begin
                        err_count <= 8'd0;
                        win_cnt   <= '0;
                    end else if (start) begin
                        expected   <= pred_obs;
                        win_cnt    <= WIN_INIT;
                        err_count  <= 8'd0;
                        first_exp  <= '0;
                        first_got  <= '0;
                        first_flag <= 1'b0;
                    end
                end
                CHECK: begin
                    if (clear) begin
                        // Abort: no compare on this edge.
                        err_count <= 8'd0;
                        win_cnt   <= '0;
                    end else begin
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                            if (!first_flag) begin
                                first_exp  <= expected;
                                first_got  <= count;
                                first_flag <= 1'b1;
                            end
                        end
                        expected <= pred_run;
                        win_cnt  <= win_cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CHECK);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == 8'd0);

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: three instances (resync, free-running prediction, long window)
// share the counter stimulus; a behavioural counter drives count, faults overwrite it.
// Table rows hold per-cycle inputs and expected outputs; corner cases are hand sequences.
module tb_count_monitor;

    logic       clk;
    logic       rst_n;
    logic       load, enable, start, start_c, clear;
    logic [7:0] data_in, count, cnt;

    logic       busy_a, done_a, pass_a, ep_a;
    logic [7:0] ec_a, fe_a, fg_a;
    logic       busy_b, done_b, pass_b, ep_b;
    logic [7:0] ec_b, fe_b, fg_b;
    logic       busy_c, done_c, pass_c, ep_c;
    logic [7:0] ec_c, fe_c, fg_c;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       ld, en;
        logic [7:0] din;
        logic       st, clr, fs;
        logic [7:0] fv;
        logic       busy, done;
        logic       pa, epa;
        logic [7:0] eca;
        logic       pb, epb;
        logic [7:0] ecb;
    } row_t;

    row_t rows[$];

    count_monitor #(.WIDTH(8), .WINDOW(16), .RESYNC(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .count(count), .data_in(data_in), .load(load),
        .enable(enable), .start(start), .clear(clear), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_pulse(ep_a), .err_count(ec_a), .first_exp(fe_a), .first_got(fg_a));

    count_monitor #(.WIDTH(8), .WINDOW(16), .RESYNC(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .count(count), .data_in(data_in), .load(load),
        .enable(enable), .start(start), .clear(clear), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_pulse(ep_b), .err_count(ec_b), .first_exp(fe_b), .first_got(fg_b));

    count_monitor #(.WIDTH(8), .WINDOW(300), .RESYNC(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .count(count), .data_in(data_in), .load(load),
        .enable(enable), .start(start_c), .clear(clear), .busy(busy_c), .done(done_c),
        .pass(pass_c), .err_pulse(ep_c), .err_count(ec_c), .first_exp(fe_c), .first_got(fg_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chkn(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock: apply inputs, optional fault overwrites the counter, counter steps at the edge.
    task automatic cyc(input int ld, input int en, input int din, input int st,
                       input int stc, input int clr, input int fs, input int fv);
        load    = 1'(ld);
        enable  = 1'(en);
        data_in = 8'(din);
        start   = 1'(st);
        start_c = 1'(stc);
        clear   = 1'(clr);
        if (fs != 0) cnt = 8'(fv);
        count = cnt;
        @(posedge clk);
        if (ld != 0)      cnt = 8'(din);
        else if (en != 0) cnt = cnt + 8'd1;
        #1;
        count = cnt;
    endtask

    function automatic void add(input int ld, input int en, input int din, input int st,
                                input int clr, input int fs, input int fv,
                                input int busy, input int done,
                                input int pa, input int epa, input int eca,
                                input int pb, input int epb, input int ecb);
        row_t r;
        r.ld = 1'(ld);   r.en = 1'(en);   r.din = 8'(din);
        r.st = 1'(st);   r.clr = 1'(clr); r.fs = 1'(fs);  r.fv = 8'(fv);
        r.busy = 1'(busy); r.done = 1'(done);
        r.pa = 1'(pa);   r.epa = 1'(epa); r.eca = 8'(eca);
        r.pb = 1'(pb);   r.epb = 1'(epb); r.ecb = 8'(ecb);
        rows.push_back(r);
    endfunction

    task automatic run_rows();
        foreach (rows[i]) begin
            row_t r;
            r = rows[i];
            cyc(r.ld, r.en, r.din, r.st, 0, r.clr, r.fs, r.fv);
            chk1($sformatf("row%0d busy_a", i), busy_a, r.busy);
            chk1($sformatf("row%0d done_a", i), done_a, r.done);
            chk1($sformatf("row%0d pass_a", i), pass_a, r.pa);
            chk1($sformatf("row%0d err_pulse_a", i), ep_a, r.epa);
            chk8($sformatf("row%0d err_count_a", i), ec_a, r.eca);
            chk1($sformatf("row%0d busy_b", i), busy_b, r.busy);
            chk1($sformatf("row%0d done_b", i), done_b, r.done);
            chk1($sformatf("row%0d pass_b", i), pass_b, r.pb);
            chk1($sformatf("row%0d err_pulse_b", i), ep_b, r.epb);
            chk8($sformatf("row%0d err_count_b", i), ec_b, r.ecb);
        end
        rows.delete();
    endtask

    task automatic chk_zero(input string tag, input logic bsy, input logic dn, input logic ps,
                            input logic ep, input logic [7:0] ec, input logic [7:0] fe,
                            input logic [7:0] fg);
        chk1({tag, " busy"}, bsy, 1'b0);
        chk1({tag, " done"}, dn, 1'b0);
        chk1({tag, " pass"}, ps, 1'b0);
        chk1({tag, " err_pulse"}, ep, 1'b0);
        chk8({tag, " err_count"}, ec, 8'h00);
        chk8({tag, " first_exp"}, fe, 8'h00);
        chk8({tag, " first_got"}, fg, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        rst_n = 1'b0;
        load = 1'b0; enable = 1'b0; start = 1'b0; start_c = 1'b0; clear = 1'b0;
        data_in = 8'h00; cnt = 8'h00; count = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset a", busy_a, done_a, pass_a, ep_a, ec_a, fe_a, fg_a);
        chk_zero("reset c", busy_c, done_c, pass_c, ep_c, ec_c, fe_c, fg_c);
        rst_n = 1'b1;

        // Run 1: counter from 0, enable held, 16 clean compares.
        add(0,1,0, 1,0,0,0, 1,0, 0,0,0, 0,0,0);
        for (int k = 1; k <= 16; k++)
            add(0,1,0, 0,0,0,0, (k < 16) ? 1 : 0, (k == 16) ? 1 : 0,
                (k == 16) ? 1 : 0,0,0, (k == 16) ? 1 : 0,0,0);
        add(0,0,0, 0,0,0,0, 0,1, 1,0,0, 1,0,0);
        // Run 2 from DONE: load FE then count across the wrap, with a few hold cycles.
        add(1,1,'hFE, 1,0,0,0, 1,0, 0,0,0, 0,0,0);
        for (int k = 1; k <= 16; k++)
            add(0, (k >= 4 && k <= 6) ? 0 : 1, 0, 0,0,0,0,
                (k < 16) ? 1 : 0, (k == 16) ? 1 : 0,
                (k == 16) ? 1 : 0,0,0, (k == 16) ? 1 : 0,0,0);
        // Run 3: load 02, counter jumps to 05 where 04 is expected at the third compare.
        add(1,1,2, 1,0,0,0, 1,0, 0,0,0, 0,0,0);
        for (int k = 1; k <= 16; k++)
            add(0,1,0, 0,0, (k == 3) ? 1 : 0, 5,
                (k < 16) ? 1 : 0, (k == 16) ? 1 : 0,
                0, (k == 3) ? 1 : 0, (k >= 3) ? 1 : 0,
                0, (k >= 3) ? 1 : 0, (k >= 3) ? k - 2 : 0);
        run_rows();
        chk8("run3 first_exp_a", fe_a, 8'h04);
        chk8("run3 first_got_a", fg_a, 8'h05);
        chk8("run3 first_exp_b", fe_b, 8'h04);
        chk8("run3 first_got_b", fg_b, 8'h05);

        // clear beats start in DONE and in IDLE; clear mid-run masks the compare on that edge.
        add(0,0,0, 1,1,0,0, 0,0, 0,0,0, 0,0,0);
        add(0,0,0, 1,1,0,0, 0,0, 0,0,0, 0,0,0);
        add(1,1,'h40, 1,0,0,0, 1,0, 0,0,0, 0,0,0);
        add(0,1,0, 0,0,0,0, 1,0, 0,0,0, 0,0,0);
        add(0,1,0, 0,1,1,'hAA, 0,0, 0,0,0, 0,0,0);
        add(0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0);
        run_rows();
        chk8("after clear first_exp_a", fe_a, 8'h00);
        chk8("after clear first_got_a", fg_a, 8'h00);

        // Reset mid-CHECK after two errors.
        cyc(1,1,'h10, 1,0,0, 0,0);
        chk1("rst seq busy_a", busy_a, 1'b1);
        cyc(0,1,0, 0,0,0, 1,'h20);
        chk1("rst seq pulse1_a", ep_a, 1'b1);
        chk8("rst seq ec1_a", ec_a, 8'd1);
        cyc(0,1,0, 0,0,0, 1,'h30);
        chk8("rst seq ec2_a", ec_a, 8'd2);
        cyc(0,1,0, 0,0,0, 0,0);
        cyc(0,1,0, 0,0,0, 0,0);
        chk8("rst seq ec_a before reset", ec_a, 8'd2);
        chk1("rst seq busy_a before reset", busy_a, 1'b1);
        chk8("rst seq ec_b before reset", ec_b, 8'd4);
        chk1("rst seq pulse_b before reset", ep_b, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("midrun reset a", busy_a, done_a, pass_a, ep_a, ec_a, fe_a, fg_a);
        chk_zero("midrun reset b", busy_b, done_b, pass_b, ep_b, ec_b, fe_b, fg_b);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0,0,0, 0,0,0, 0,0);
        chk1("post reset busy_a", busy_a, 1'b0);
        chk1("post reset done_a", done_a, 1'b0);
        cyc(1,1,0, 1,0,0, 0,0);
        for (int k = 1; k <= 16; k++) cyc(0,1,0, 0,0,0, 0,0);
        chk1("clean rerun done_a", done_a, 1'b1);
        chk1("clean rerun pass_a", pass_a, 1'b1);
        chk8("clean rerun ec_a", ec_a, 8'd0);
        chk1("clean rerun pass_b", pass_b, 1'b1);

        // Long window, count stuck at 0 with enable high: every compare fails, total saturates.
        chk1("c idle before run", busy_c, 1'b0);
        cyc(0,1,0, 0,1,0, 1,0);
        chk1("c busy after start", busy_c, 1'b1);
        pulses = 0;
        for (int k = 1; k <= 300; k++) begin
            cyc(0,1,0, 0,0,0, 1,0);
            if (ep_c === 1'b1) pulses++;
            if (k == 1)   chk8("c ec k1", ec_c, 8'd1);
            if (k == 254) chk8("c ec k254", ec_c, 8'd254);
            if (k == 255) begin
                chk8("c ec k255", ec_c, 8'd255);
                chk1("c pulse k255", ep_c, 1'b1);
            end
            if (k == 256) begin
                chk8("c ec k256 saturated", ec_c, 8'd255);
                chk1("c pulse k256", ep_c, 1'b1);
                chk1("c busy k256", busy_c, 1'b1);
            end
            if (k == 299) chk1("c done k299", done_c, 1'b0);
        end
        chk1("c done", done_c, 1'b1);
        chk1("c busy end", busy_c, 1'b0);
        chk1("c pass", pass_c, 1'b0);
        chk8("c ec end", ec_c, 8'd255);
        chk1("c pulse on last compare", ep_c, 1'b1);
        chkn("c pulse total", pulses, 300);
        chk8("c first_exp", fe_c, 8'h01);
        chk8("c first_got", fg_c, 8'h00);
        cyc(0,0,0, 0,1,1, 0,0);
        chk1("c clear+start done", done_c, 1'b0);
        chk1("c clear+start busy", busy_c, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
